// File: rtl/clock_hms.sv
// Time-of-day counter: divides the system clock to a 1 Hz tick, keeps HH:MM:SS as
// six BCD digits, accepts per-field set increments and flags the 23:59:59 -> 00:00:00 wrap.
module clock_hms #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        run,
    input  logic [2:0]  cnt_inc,
    output logic        full_flag,
    output logic        sec_tick,
    output logic [31:0] Data
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          sec_tick_q, sec_tick_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    hr_q, hr_d;
    logic [31:0]   data_q, data_d;

    logic          set_any;
    logic          tick_adv;
    logic          at_day_end;

    // Packed BCD pair {tens, units}, wrapping 59 -> 00.
    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Packed BCD pair {tens, units}, wrapping 23 -> 00.
    function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    assign set_any    = |cnt_inc;
    assign tick_adv   = sec_tick_q & run & ~set_any;
    assign at_day_end = (sec_q == 8'h59) && (min_q == 8'h59) && (hr_q == 8'h23);

    always_comb begin
        div_cnt_d  = div_cnt_q;
        sec_tick_d = 1'b0;
        if (run) begin
            sec_tick_d = (div_cnt_q == DIV_MAX);
            div_cnt_d  = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
        end
    end

    // A set increment takes precedence over a coincident tick, which is dropped.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (set_any) begin
            if (cnt_inc[0]) sec_d = inc_bcd60(sec_q);
            if (cnt_inc[1]) min_d = inc_bcd60(min_q);
            if (cnt_inc[2]) hr_d  = inc_bcd24(hr_q);
        end else if (tick_adv) begin
            sec_d = inc_bcd60(sec_q);
            if (sec_q == 8'h59) begin
                min_d = inc_bcd60(min_q);
                if (min_q == 8'h59) hr_d = inc_bcd24(hr_q);
            end
        end
    end

    always_comb begin
        data_d = {sec_q[3:0], sec_q[7:4], min_q[3:0], min_q[7:4],
                  hr_q[3:0], hr_q[7:4], 4'h0, 4'h1};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt_q  <= '0;
            sec_tick_q <= 1'b0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hr_q       <= 8'h00;
            data_q     <= 32'h0000_0001;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sec_tick_q <= sec_tick_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            data_q     <= data_d;
        end
    end

    assign full_flag = tick_adv & at_day_end;
    assign sec_tick  = sec_tick_q;
    assign Data      = data_q;

endmodule
